// File: rtl/xrouter_pkg.sv
// xrouter_pkg: default build constants shared by the skid-buffered crossbar
// router and its round-robin arbiter.
//   N_I_DEF / N_T_DEF : default initiator / target port counts
//   VDW_DEF           : default packet width {init_tag, tgt_tag, addr+data}
//   SEL_LSB_DEF/SEL_W_DEF : default position and width of the target-select field
//   ERR_W             : width of the saturating decode-error counter
package xrouter_pkg;

  localparam int N_I_DEF     = 3;
  localparam int N_T_DEF     = 5;
  localparam int VDW_DEF     = 66;
  localparam int SEL_LSB_DEF = 61;
  localparam int SEL_W_DEF   = 3;
  localparam int ERR_W       = 16;

endpackage

// File: rtl/xrouter_rr_arb.sv
// xrouter_rr_arb: N-way round-robin arbiter with a registered priority pointer.
//   clk, rstn : clock, synchronous active-low reset (pointer -> 0)
//   req       : per-requester request
//   en        : arbitration enable; no grant is issued while low
//   gnt       : one-hot grant, combinational from req/en/pointer
// The pointer names the highest-priority requester and moves to winner+1 only
// when a grant is actually issued.
module xrouter_rr_arb
  import xrouter_pkg::*;
#(
  parameter int N = N_I_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic          found;
  int            win;
  int            idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    win   = 0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (en && found) gnt[PW'(win)] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (win == N - 1) ? '0 : PW'(win + 1);
    end
  end

endmodule

// File: rtl/xrouter_skid.sv
// xrouter_skid: N_I x N_T packet crossbar with a 2-entry skid FIFO per target.
//   clk, rstn : clock, synchronous active-low reset
//   i_vld/i_pkt/i_gnt : initiator side; a packet is consumed when i_vld & i_gnt
//   t_vld/t_pkt/t_rdy : target side, registered outputs; pop when t_vld & t_rdy
//   err_pulse : one-cycle pulse per initiator after a decode-error packet is dropped
//   err_cnt   : saturating total of dropped decode-error packets
// Target space comes only from the registered FIFO count, so there is no
// combinational path from t_rdy to i_gnt.
module xrouter_skid
  import xrouter_pkg::*;
#(
  parameter int N_I     = N_I_DEF,
  parameter int N_T     = N_T_DEF,
  parameter int VDW     = VDW_DEF,
  parameter int SEL_LSB = SEL_LSB_DEF,
  parameter int SEL_W   = SEL_W_DEF
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_I-1:0]            i_vld,
  input  logic [N_I-1:0][VDW-1:0]   i_pkt,
  output logic [N_I-1:0]            i_gnt,
  input  logic [N_T-1:0]            t_rdy,
  output logic [N_T-1:0]            t_vld,
  output logic [N_T-1:0][VDW-1:0]   t_pkt,
  output logic [N_I-1:0]            err_pulse,
  output logic [ERR_W-1:0]          err_cnt
);

  logic [N_I-1:0][SEL_W-1:0] sel;
  logic [N_I-1:0]            dec_err;
  logic [N_T-1:0][N_I-1:0]   req;
  logic [N_T-1:0][N_I-1:0]   tgnt;
  logic [4:0]                n_err;
  logic [ERR_W:0]            err_sum;

  always_comb begin
    sel     = '0;
    dec_err = '0;
    req     = '0;
    for (int i = 0; i < N_I; i++) begin
      sel[i]     = i_pkt[i][SEL_LSB +: SEL_W];
      dec_err[i] = i_vld[i] && (int'(sel[i]) >= N_T);
      for (int k = 0; k < N_T; k++) begin
        req[k][i] = i_vld[i] && !dec_err[i] && (int'(sel[i]) == k);
      end
    end
  end

  // Decode errors are always accepted; arbiter grants are already gated by reset.
  always_comb begin
    i_gnt = dec_err & {N_I{rstn}};
    for (int k = 0; k < N_T; k++) i_gnt = i_gnt | tgnt[k];
  end

  for (genvar k = 0; k < N_T; k++) begin : g_tgt
    logic [1:0]     cnt;
    logic [VDW-1:0] mem0;
    logic [VDW-1:0] mem1;
    logic [VDW-1:0] din;
    logic           push;
    logic           pop;
    logic           space;

    assign space = (cnt != 2'd2);
    assign pop   = (cnt != 2'd0) && t_rdy[k];

    xrouter_rr_arb #(.N(N_I)) u_arb (
      .clk  (clk),
      .rstn (rstn),
      .req  (req[k]),
      .en   (space && rstn),
      .gnt  (tgnt[k])
    );

    always_comb begin
      din  = '0;
      push = |tgnt[k];
      for (int i = 0; i < N_I; i++) begin
        if (tgnt[k][i]) din = i_pkt[i];
      end
    end

    // mem0 is the head and drives t_pkt directly; mem1 is the skid slot.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        cnt  <= 2'd0;
        mem0 <= '0;
        mem1 <= '0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (cnt == 2'd0) mem0 <= din;
            else             mem1 <= din;
            cnt <= cnt + 2'd1;
          end
          2'b01: begin
            mem0 <= mem1;
            cnt  <= cnt - 2'd1;
          end
          2'b11: begin
            if (cnt == 2'd1) begin
              mem0 <= din;
            end else begin
              mem0 <= mem1;
              mem1 <= din;
            end
          end
          default: ;
        endcase
      end
    end

    assign t_vld[k] = (cnt != 2'd0);
    assign t_pkt[k] = mem0;

`ifndef SYNTHESIS
    always @(posedge clk) begin
      if (rstn && t_vld[k]) begin
        assert (int'(t_pkt[k][SEL_LSB +: SEL_W]) == k)
          else $error("t_pkt[%0d] carries select %0d", k, t_pkt[k][SEL_LSB +: SEL_W]);
      end
    end
`endif
  end

  always_comb begin
    n_err = '0;
    for (int i = 0; i < N_I; i++) n_err = n_err + 5'(dec_err[i]);
    err_sum = {1'b0, err_cnt} + (ERR_W + 1)'(n_err);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_pulse <= '0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= dec_err;
      err_cnt   <= err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
    end
  end

endmodule
